idma_eh_policy_ctrl: RTL and testbench
======================================

Name: idma_eh_policy_ctrl

Overview:
- Error-policy sequencer between the iDMA backend response/error-handling ports and the frontend.
- Forwards backend 1D responses to the frontend and monitors them for errors.
- On each error, produces the CONTINUE/ABORT decision on the backend's error-handling request stream. The decision comes from a configured policy: automatic, threshold-based, or software-decided with timeout.
- Keeps a saturating error counter and exposes pending/timeout status to the register frontend.

Parameters:
AddrWidth, 32, width of reported burst address
CntWidth, 8, width of error counter and threshold
TimeoutCycles, 1024, software-decision timeout in cycles; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
be_rsp_valid_i  in  1  backend 1D response valid
be_rsp_ready_o  out  1  backend 1D response ready
be_rsp_error_i  in  1  response carries an error
be_rsp_last_i  in  1  response last flag
be_rsp_cause_i  in  2  bus response code of error
be_rsp_err_type_i  in  2  error type (read/write/...)
be_rsp_addr_i  in  AddrWidth  faulting burst address
fe_rsp_valid_o  out  1  frontend response valid
fe_rsp_ready_i  in  1  frontend response ready
fe_rsp_error_o, fe_rsp_last_o, fe_rsp_cause_o, fe_rsp_err_type_o, fe_rsp_addr_o  out  1/1/2/2/AddrWidth  forwarded response fields
eh_o  out  1  decision: 0=CONTINUE, 1=ABORT
eh_valid_o  out  1  decision valid
eh_ready_i  in  1  backend accepts decision
cfg_mode_i  in  2  0=AUTO_CONTINUE, 1=AUTO_ABORT, 2=SW, 3=THRESH
cfg_thresh_i  in  CntWidth  abort threshold for THRESH mode
sw_eh_i  in  1  software decision (0/1 as eh_o)
sw_eh_valid_i  in  1  software decision valid
sw_eh_ready_o  out  1  software decision ready
err_cnt_clr_i  in  1  clear error counter
err_cnt_o  out  CntWidth  errors seen since reset/clear
err_pending_o  out  1  waiting for software decision
timeout_o  out  1  one-cycle pulse on software timeout
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset: all registers reset synchronously when rst_i=1.
  - state=IDLE, err_cnt=0, timer=0, decision=CONTINUE, timeout_o=0.
  - While rst_i=1: be_rsp_ready_o=0, fe_rsp_valid_o=0, eh_valid_o=0, sw_eh_ready_o=0.
  - Reset mid-operation discards any pending decision; no eh handshake is issued.
- Response forwarding, IDLE only:
  - fe_rsp_* = be_rsp_*; fe_rsp_valid_o=be_rsp_valid_i; be_rsp_ready_o=fe_rsp_ready_i. Combinational, zero latency.
  - In every other state, fe_rsp_valid_o=0 and be_rsp_ready_o=0. This blocks further responses until the decision is accepted.
- Error capture: on an IDLE handshake (be_rsp_valid_i & fe_rsp_ready_i) with be_rsp_error_i=1:
  - err_cnt increments; cfg_mode_i and cfg_thresh_i are sampled this cycle.
  - Mode 0 -> decision CONTINUE, go to ISSUE.
  - Mode 1 -> decision ABORT, go to ISSUE.
  - Mode 3 -> decision ABORT if cfg_thresh_i!=0 and the post-increment count >= cfg_thresh_i, else CONTINUE; go to ISSUE.
  - Mode 2 -> go to WAIT_SW, timer=0.
  - Non-error handshakes leave state and counter unchanged.
- WAIT_SW:
  - Outputs: sw_eh_ready_o=1, err_pending_o=1; timer increments each cycle.
  - On sw_eh_valid_i: decision=sw_eh_i, go to ISSUE.
  - Else if TimeoutCycles!=0 and timer==TimeoutCycles-1: decision=ABORT, timeout_o=1 for that cycle, go to ISSUE.
  - sw_eh_valid_i in the same cycle as expiry: software wins, no timeout pulse.
- ISSUE:
  - eh_valid_o=1; eh_o=decision, held stable until handshake.
  - On eh_ready_i go to IDLE. A backend extra response emitted after the decision is then forwarded normally.
- Latency:
  - Auto modes: eh_valid_o is asserted the cycle after the error handshake.
  - SW mode: eh_valid_o is asserted the cycle after the sw handshake or the timeout cycle.
- Counter:
  - Saturates at all-ones.
  - err_cnt_clr_i has priority over a held value; clear and increment in the same cycle -> 1.
  - The THRESH comparison uses the count as if cleared, then incremented.
- busy_o = (state!=IDLE). err_pending_o = (state==WAIT_SW).

Test Plan:
- Mode 0: non-error rsp with fe_rsp_ready_i=1 -> forwarded the same cycle. Error rsp at addr 0x1000 -> forwarded with addr 0x1000; next cycle eh_valid_o=1, eh_o=0; err_cnt=1.
- Mode 3, thresh=3: three error rsps each acked -> decisions 0,0,1; err_cnt=3. Backend responses are blocked (be_rsp_ready_o=0) while eh_valid_o=1 and eh_ready_i=0.
- Mode 2, TimeoutCycles=16:
  - sw_eh_i=1 after 5 cycles -> eh_o=1 the next cycle, timeout_o never pulses.
  - No sw input -> timeout_o pulses on cycle 16 of WAIT_SW, eh_o=1.
  - sw_eh_valid_i exactly on cycle 16 -> software value used, no pulse.
- Saturation with CntWidth=2: five errors -> err_cnt=3. err_cnt_clr_i coincident with the next error -> err_cnt=1.
- rst_i asserted in WAIT_SW and in ISSUE -> next cycle state IDLE, eh_valid_o=0, err_cnt=0, no eh handshake observed.
- Back-to-back error then OK rsp from backend -> OK rsp held (not forwarded) until the eh handshake completes, then forwarded in the first IDLE cycle.

Source files
------------

// File: rtl/idma_eh_policy_ctrl.sv
// idma_eh_policy_ctrl
//   Error-policy sequencer between the iDMA backend response/error-handling
//   ports and the frontend. In IDLE, backend 1D responses pass through to the
//   frontend with no latency. When an error response is accepted, forwarding
//   stops until the CONTINUE/ABORT decision has been handed to the backend.
//   The decision is made automatically, by an error threshold, or by software
//   with a timeout fallback to ABORT. A saturating error counter and the
//   pending/timeout status are exported to the register frontend.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   be_rsp_*               backend 1D response stream (valid/ready + fields)
//   fe_rsp_*               forwarded response stream to the frontend
//   eh_o/eh_valid_o/eh_ready_i   decision stream to backend (0=CONTINUE, 1=ABORT)
//   cfg_mode_i, cfg_thresh_i     policy: 0=AUTO_CONTINUE 1=AUTO_ABORT 2=SW 3=THRESH
//   sw_eh_*                software decision stream
//   err_cnt_clr_i, err_cnt_o     error counter clear / value
//   err_pending_o, timeout_o, busy_o   status
module idma_eh_policy_ctrl #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 be_rsp_valid_i,
  output logic                 be_rsp_ready_o,
  input  logic                 be_rsp_error_i,
  input  logic                 be_rsp_last_i,
  input  logic [1:0]           be_rsp_cause_i,
  input  logic [1:0]           be_rsp_err_type_i,
  input  logic [AddrWidth-1:0] be_rsp_addr_i,
  output logic                 fe_rsp_valid_o,
  input  logic                 fe_rsp_ready_i,
  output logic                 fe_rsp_error_o,
  output logic                 fe_rsp_last_o,
  output logic [1:0]           fe_rsp_cause_o,
  output logic [1:0]           fe_rsp_err_type_o,
  output logic [AddrWidth-1:0] fe_rsp_addr_o,
  output logic                 eh_o,
  output logic                 eh_valid_o,
  input  logic                 eh_ready_i,
  input  logic [1:0]           cfg_mode_i,
  input  logic [CntWidth-1:0]  cfg_thresh_i,
  input  logic                 sw_eh_i,
  input  logic                 sw_eh_valid_i,
  output logic                 sw_eh_ready_o,
  input  logic                 err_cnt_clr_i,
  output logic [CntWidth-1:0]  err_cnt_o,
  output logic                 err_pending_o,
  output logic                 timeout_o,
  output logic                 busy_o
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitSw = 2'd1,
    StIssue  = 2'd2
  } state_e;

  localparam int unsigned TimerWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   err_cnt_q, err_cnt_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic                  decision_q, decision_d;
  logic                  timeout_pulse;

  logic                  is_idle;
  logic                  err_hs;
  logic [CntWidth-1:0]   cnt_base;
  logic [CntWidth-1:0]   cnt_inc;
  logic                  thresh_hit;

  assign is_idle = (state_q == StIdle);

  // Reset overrides every handshake output so nothing is exchanged while the
  // state registers are still being cleared.
  assign be_rsp_ready_o = ~rst_i & is_idle & fe_rsp_ready_i;
  assign fe_rsp_valid_o = ~rst_i & is_idle & be_rsp_valid_i;
  assign eh_valid_o     = ~rst_i & (state_q == StIssue);
  assign sw_eh_ready_o  = ~rst_i & (state_q == StWaitSw);
  assign timeout_o      = ~rst_i & timeout_pulse;

  assign fe_rsp_error_o    = be_rsp_error_i;
  assign fe_rsp_last_o     = be_rsp_last_i;
  assign fe_rsp_cause_o    = be_rsp_cause_i;
  assign fe_rsp_err_type_o = be_rsp_err_type_i;
  assign fe_rsp_addr_o     = be_rsp_addr_i;

  assign eh_o          = decision_q;
  assign err_cnt_o     = err_cnt_q;
  assign err_pending_o = (state_q == StWaitSw);
  assign busy_o        = ~is_idle;

  assign err_hs = be_rsp_valid_i & be_rsp_ready_o & be_rsp_error_i;

  // A clear applies first, so a coincident error lands on a count of one and
  // the threshold is compared against that same post-clear value.
  always_comb begin
    cnt_base   = err_cnt_clr_i ? '0 : err_cnt_q;
    cnt_inc    = (&cnt_base) ? cnt_base : cnt_base + 1'b1;
    err_cnt_d  = err_hs ? cnt_inc : cnt_base;
    thresh_hit = (cfg_thresh_i != '0) && (cnt_inc >= cfg_thresh_i);
  end

  always_comb begin
    state_d       = state_q;
    decision_d    = decision_q;
    timer_d       = timer_q;
    timeout_pulse = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (err_hs) begin
          unique case (cfg_mode_i)
            2'd0: begin decision_d = 1'b0;       state_d = StIssue;  end
            2'd1: begin decision_d = 1'b1;       state_d = StIssue;  end
            2'd2: begin timer_d    = '0;         state_d = StWaitSw; end
            default: begin decision_d = thresh_hit; state_d = StIssue; end
          endcase
        end
      end
      StWaitSw: begin
        timer_d = timer_q + 1'b1;
        // Software wins over a timeout expiring in the same cycle.
        if (sw_eh_valid_i) begin
          decision_d = sw_eh_i;
          state_d    = StIssue;
        end else if ((TimeoutCycles != 0) && (timer_q == TimerLast)) begin
          decision_d    = 1'b1;
          timeout_pulse = 1'b1;
          state_d       = StIssue;
        end
      end
      StIssue: begin
        if (eh_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      err_cnt_q  <= '0;
      timer_q    <= '0;
      decision_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      timer_q    <= timer_d;
      decision_q <= decision_d;
    end
  end

endmodule

// File: tb/tb_idma_eh_policy_ctrl.sv
// Testbench for idma_eh_policy_ctrl (CntWidth=2, TimeoutCycles=16).
// Expected decisions are pushed to a queue by a small policy model when an
// error response is accepted and popped when the DUT hands out a decision.
module tb_idma_eh_policy_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned CW = 2;
  localparam int unsigned TO = 16;

  logic          clk;
  logic          rst_i;
  logic          be_rsp_valid_i, be_rsp_ready_o, be_rsp_error_i, be_rsp_last_i;
  logic [1:0]    be_rsp_cause_i, be_rsp_err_type_i;
  logic [AW-1:0] be_rsp_addr_i;
  logic          fe_rsp_valid_o, fe_rsp_ready_i, fe_rsp_error_o, fe_rsp_last_o;
  logic [1:0]    fe_rsp_cause_o, fe_rsp_err_type_o;
  logic [AW-1:0] fe_rsp_addr_o;
  logic          eh_o, eh_valid_o, eh_ready_i;
  logic [1:0]    cfg_mode_i;
  logic [CW-1:0] cfg_thresh_i;
  logic          sw_eh_i, sw_eh_valid_i, sw_eh_ready_o;
  logic          err_cnt_clr_i;
  logic [CW-1:0] err_cnt_o;
  logic          err_pending_o, timeout_o, busy_o;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  int to_cnt = 0;
  int exp_cnt = 0;
  bit exp_q[$];

  idma_eh_policy_ctrl #(.AddrWidth(AW), .CntWidth(CW), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .be_rsp_valid_i(be_rsp_valid_i), .be_rsp_ready_o(be_rsp_ready_o),
    .be_rsp_error_i(be_rsp_error_i), .be_rsp_last_i(be_rsp_last_i),
    .be_rsp_cause_i(be_rsp_cause_i), .be_rsp_err_type_i(be_rsp_err_type_i),
    .be_rsp_addr_i(be_rsp_addr_i),
    .fe_rsp_valid_o(fe_rsp_valid_o), .fe_rsp_ready_i(fe_rsp_ready_i),
    .fe_rsp_error_o(fe_rsp_error_o), .fe_rsp_last_o(fe_rsp_last_o),
    .fe_rsp_cause_o(fe_rsp_cause_o), .fe_rsp_err_type_o(fe_rsp_err_type_o),
    .fe_rsp_addr_o(fe_rsp_addr_o),
    .eh_o(eh_o), .eh_valid_o(eh_valid_o), .eh_ready_i(eh_ready_i),
    .cfg_mode_i(cfg_mode_i), .cfg_thresh_i(cfg_thresh_i),
    .sw_eh_i(sw_eh_i), .sw_eh_valid_i(sw_eh_valid_i), .sw_eh_ready_o(sw_eh_ready_o),
    .err_cnt_clr_i(err_cnt_clr_i), .err_cnt_o(err_cnt_o),
    .err_pending_o(err_pending_o), .timeout_o(timeout_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe what the next rising edge will capture: inputs are driven on the
  // falling edge, so 2 time units later everything has settled.
  always @(negedge clk) begin
    #2;
    if (!rst_i && eh_valid_o && eh_ready_i) hs_cnt++;
    if (timeout_o) to_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Policy model for a newly accepted error response.
  task automatic model_error(input bit clr);
    if (clr) exp_cnt = 0;
    if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    case (cfg_mode_i)
      2'd0: exp_q.push_back(1'b0);
      2'd1: exp_q.push_back(1'b1);
      2'd3: exp_q.push_back((cfg_thresh_i != 0) && (exp_cnt >= int'(cfg_thresh_i)));
      default: ;
    endcase
  endtask

  task automatic send_rsp(input bit err, input logic [AW-1:0] addr, input bit clr);
    be_rsp_valid_i    = 1'b1;
    be_rsp_error_i    = err;
    be_rsp_last_i     = 1'b1;
    be_rsp_cause_i    = err ? 2'd2 : 2'd0;
    be_rsp_err_type_i = err ? 2'd1 : 2'd0;
    be_rsp_addr_i     = addr;
    fe_rsp_ready_i    = 1'b1;
    err_cnt_clr_i     = clr;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (be_rsp_ready_o) break;
      cycle();
    end
    checks++;
    if (be_rsp_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rsp_accept be_rsp_ready_o=%b required=1", be_rsp_ready_o);
    end
    checks++;
    if (fe_rsp_valid_o !== 1'b1 || fe_rsp_addr_o !== addr || fe_rsp_error_o !== err) begin
      failures++;
      $display("[TB] FAIL rsp_forward valid=%b addr=%h err=%b required valid=1 addr=%h err=%b",
               fe_rsp_valid_o, fe_rsp_addr_o, fe_rsp_error_o, addr, err);
    end
    if (err && be_rsp_ready_o) model_error(clr);
    cycle();
    be_rsp_valid_i = 1'b0;
    be_rsp_error_i = 1'b0;
    err_cnt_clr_i  = 1'b0;
  endtask

  task automatic drain_decision(input string name);
    bit exp;
    eh_ready_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (eh_valid_o) break;
      cycle();
    end
    checks++;
    if (eh_valid_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_eh_valid eh_valid_o=%b required=1", name, eh_valid_o);
    end else if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s_unexpected_decision eh_o=%b required none", name, eh_o);
    end else begin
      exp = exp_q.pop_front();
      if (eh_o !== exp) begin
        failures++;
        $display("[TB] FAIL %s_decision eh_o=%b required=%b", name, eh_o, exp);
      end
    end
    cycle();
    eh_ready_i = 1'b0;
  endtask

  task automatic clear_counter();
    err_cnt_clr_i = 1'b1;
    exp_cnt = 0;
    cycle();
    err_cnt_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    be_rsp_valid_i = 1'b1; fe_rsp_ready_i = 1'b1;
    sw_eh_valid_i = 1'b1; eh_ready_i = 1'b1;
    cycle();
    cycle();
    #1;
    checks++;
    if ({be_rsp_ready_o, fe_rsp_valid_o, eh_valid_o, sw_eh_ready_o} !== 4'b0) begin
      failures++;
      $display("[TB] FAIL reset_gating be_rdy/fe_vld/eh_vld/sw_rdy=%b required=0000",
               {be_rsp_ready_o, fe_rsp_valid_o, eh_valid_o, sw_eh_ready_o});
    end
    be_rsp_valid_i = 1'b0; sw_eh_valid_i = 1'b0; eh_ready_i = 1'b0;
    rst_i = 1'b0;
    exp_cnt = 0;
    #1;
    checks++;
    if (err_cnt_o !== CW'(exp_cnt) || busy_o !== 1'b0 || err_pending_o !== 1'b0 ||
        eh_valid_o !== 1'b0 || timeout_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_state cnt=%0d busy=%b pend=%b ehv=%b to=%b required 0/0/0/0/0",
               err_cnt_o, busy_o, err_pending_o, eh_valid_o, timeout_o);
    end
    cycle();
  endtask

  task automatic test_mode0();
    cfg_mode_i = 2'd0;
    send_rsp(1'b0, 32'h0000_2000, 1'b0);
    send_rsp(1'b1, 32'h0000_1000, 1'b0);
    #1;
    checks++;
    if (eh_valid_o !== 1'b1 || busy_o !== 1'b1 || err_cnt_o !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL mode0_latency ehv=%b busy=%b cnt=%0d required 1/1/%0d",
               eh_valid_o, busy_o, err_cnt_o, exp_cnt);
    end
    drain_decision("mode0");
  endtask

  task automatic test_thresh();
    cfg_mode_i = 2'd3;
    cfg_thresh_i = 2'd3;
    clear_counter();
    for (int i = 0; i < 3; i++) begin
      send_rsp(1'b1, 32'h0000_4000 + 32'(i * 16), 1'b0);
      be_rsp_valid_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
        #1;
        checks++;
        if (eh_valid_o !== 1'b1 || be_rsp_ready_o !== 1'b0 || fe_rsp_valid_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL thresh_block ehv=%b be_rdy=%b fe_vld=%b required 1/0/0",
                   eh_valid_o, be_rsp_ready_o, fe_rsp_valid_o);
        end
        cycle();
      end
      be_rsp_valid_i = 1'b0;
      drain_decision("thresh");
    end
    #1;
    checks++;
    if (err_cnt_o !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL thresh_count cnt=%0d required=%0d", err_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_sw_decision();
    int to0;
    cfg_mode_i = 2'd2;
    to0 = to_cnt;
    send_rsp(1'b1, 32'h0000_5000, 1'b0);
    #1;
    checks++;
    if (err_pending_o !== 1'b1 || sw_eh_ready_o !== 1'b1 || eh_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sw_pending pend=%b sw_rdy=%b ehv=%b required 1/1/0",
               err_pending_o, sw_eh_ready_o, eh_valid_o);
    end
    repeat (5) cycle();
    sw_eh_valid_i = 1'b1; sw_eh_i = 1'b1;
    exp_q.push_back(1'b1);
    cycle();
    sw_eh_valid_i = 1'b0; sw_eh_i = 1'b0;
    #1;
    checks++;
    if (eh_valid_o !== 1'b1 || eh_o !== 1'b1 || to_cnt !== to0) begin
      failures++;
      $display("[TB] FAIL sw_latency ehv=%b eh=%b pulses=%0d required 1/1/%0d",
               eh_valid_o, eh_o, to_cnt, to0);
    end
    drain_decision("sw");
  endtask

  task automatic test_sw_timeout();
    int n;
    int pulse_at;
    int to0;
    cfg_mode_i = 2'd2;
    to0 = to_cnt;
    n = 0;
    pulse_at = -1;
    send_rsp(1'b1, 32'h0000_6000, 1'b0);
    exp_q.push_back(1'b1);
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!err_pending_o) break;
      n++;
      if (timeout_o) pulse_at = n;
      cycle();
    end
    checks++;
    if (pulse_at !== int'(TO) || n !== int'(TO) || to_cnt !== to0 + 1) begin
      failures++;
      $display("[TB] FAIL timeout_pulse pulse_cycle=%0d wait_cycles=%0d pulses=%0d required %0d/%0d/1",
               pulse_at, n, to_cnt - to0, TO, TO);
    end
    drain_decision("timeout");
  endtask

  task automatic test_sw_race();
    int to0;
    cfg_mode_i = 2'd2;
    send_rsp(1'b1, 32'h0000_7000, 1'b0);
    exp_q.push_back(1'b0);
    to0 = to_cnt;
    for (int n = 1; n <= int'(TO); n++) begin
      if (n == int'(TO)) begin
        sw_eh_valid_i = 1'b1; sw_eh_i = 1'b0;
        #1;
        checks++;
        if (err_pending_o !== 1'b1 || timeout_o !== 1'b0) begin
          failures++;
          $display("[TB] FAIL race_no_pulse pend=%b to=%b required 1/0", err_pending_o, timeout_o);
        end
      end
      cycle();
    end
    sw_eh_valid_i = 1'b0;
    checks++;
    if (to_cnt !== to0) begin
      failures++;
      $display("[TB] FAIL race_pulse_count pulses=%0d required=%0d", to_cnt, to0);
    end
    drain_decision("race");
  endtask

  task automatic test_saturation();
    cfg_mode_i = 2'd0;
    clear_counter();
    for (int i = 0; i < 5; i++) begin
      send_rsp(1'b1, 32'h0000_8000 + 32'(i), 1'b0);
      drain_decision("sat");
    end
    #1;
    checks++;
    if (err_cnt_o !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL sat_count cnt=%0d required=%0d", err_cnt_o, exp_cnt);
    end
    send_rsp(1'b1, 32'h0000_8100, 1'b1);
    drain_decision("clr");
    #1;
    checks++;
    if (err_cnt_o !== CW'(exp_cnt)) begin
      failures++;
      $display("[TB] FAIL clr_inc_count cnt=%0d required=%0d", err_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit exp;
    cfg_mode_i = 2'd0;
    send_rsp(1'b1, 32'h0000_9000, 1'b0);
    be_rsp_valid_i = 1'b1; be_rsp_addr_i = 32'h0000_3000;
    be_rsp_error_i = 1'b0; fe_rsp_ready_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (fe_rsp_valid_o !== 1'b0 || be_rsp_ready_o !== 1'b0) begin
        failures++;
        $display("[TB] FAIL b2b_hold fe_vld=%b be_rdy=%b required 0/0", fe_rsp_valid_o, be_rsp_ready_o);
      end
      cycle();
    end
    eh_ready_i = 1'b1;
    #1;
    checks++;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
    if (eh_valid_o !== 1'b1 || eh_o !== exp || fe_rsp_valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_decision ehv=%b eh=%b fe_vld=%b required 1/%b/0",
               eh_valid_o, eh_o, fe_rsp_valid_o, exp);
    end
    cycle();
    eh_ready_i = 1'b0;
    #1;
    checks++;
    if (fe_rsp_valid_o !== 1'b1 || fe_rsp_addr_o !== 32'h0000_3000 || be_rsp_ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_release fe_vld=%b addr=%h be_rdy=%b required 1/00003000/1",
               fe_rsp_valid_o, fe_rsp_addr_o, be_rsp_ready_o);
    end
    cycle();
    be_rsp_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid(input logic [1:0] mode, input string name);
    int hs0;
    cfg_mode_i = mode;
    send_rsp(1'b1, 32'h0000_A000, 1'b0);
    cycle();
    hs0 = hs_cnt;
    rst_i = 1'b1; eh_ready_i = 1'b1;
    cycle();
    rst_i = 1'b0; eh_ready_i = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || eh_valid_o !== 1'b0 || err_cnt_o !== CW'(exp_cnt) || hs_cnt !== hs0) begin
      failures++;
      $display("[TB] FAIL %s busy=%b ehv=%b cnt=%0d handshakes=%0d required 0/0/0/%0d",
               name, busy_o, eh_valid_o, err_cnt_o, hs_cnt, hs0);
    end
    cycle();
  endtask

  initial begin
    rst_i = 1'b1;
    be_rsp_valid_i = 1'b0; be_rsp_error_i = 1'b0; be_rsp_last_i = 1'b0;
    be_rsp_cause_i = 2'd0; be_rsp_err_type_i = 2'd0; be_rsp_addr_i = '0;
    fe_rsp_ready_i = 1'b0; eh_ready_i = 1'b0;
    cfg_mode_i = 2'd0; cfg_thresh_i = '0;
    sw_eh_i = 1'b0; sw_eh_valid_i = 1'b0; err_cnt_clr_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_mode0();
    test_thresh();
    test_sw_decision();
    test_sw_timeout();
    test_sw_race();
    test_saturation();
    test_back_to_back();
    test_reset_mid(2'd2, "reset_in_wait_sw");
    test_reset_mid(2'd0, "reset_in_issue");
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_leftover entries=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
